core_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for the single-issue core: steps fetch/decode/execute/mem/writeback one instruction at a time.

---
 rtl/core_seq_ctrl_if.sv | 41 ++++
 rtl/core_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_ctrl_if.sv
// Handshake, decode and strobe bundle between the multi-cycle sequencer and
// the core datapath (IFU/IDU/EXU and the instruction/data memories).
interface core_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic             imem_rsp_valid;
    logic             dec_is_load;
    logic             dec_is_store;
    logic             dec_is_ebreak;
    logic             dmem_req_valid;
    logic             dmem_req_wen;
    logic             dmem_req_ready;
    logic             dmem_rsp_valid;
    logic             ir_we;
    logic             rf_we;
    logic             pc_we;
    logic             halt;
    logic             mem_timeout;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    // Sequencer side
    modport master (
        output imem_req_valid, dmem_req_valid, dmem_req_wen,
               ir_we, rf_we, pc_we, halt, mem_timeout, state, instret,
        input  imem_req_ready, imem_rsp_valid,
               dec_is_load, dec_is_store, dec_is_ebreak,
               dmem_req_ready, dmem_rsp_valid
    );

    // Datapath / memory side
    modport slave (
        input  imem_req_valid, dmem_req_valid, dmem_req_wen,
               ir_we, rf_we, pc_we, halt, mem_timeout, state, instret,
        output imem_req_ready, imem_rsp_valid,
               dec_is_load, dec_is_store, dec_is_ebreak,
               dmem_req_ready, dmem_rsp_valid
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the single-issue core. Steps one instruction at a
// time through fetch/decode/execute/mem/writeback, drives the imem and dmem
// request handshakes and the IR/PC/regfile write strobes, and stops for good
// on ebreak (HALT) or when a memory wait exceeds the watchdog limit (ERR).
module core_seq_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    core_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // Watchdog wide enough to hold TIMEOUT; the last legal wait count is TIMEOUT-1.
    localparam int              WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    state_t           r_state;
    logic             r_req_acc;
    logic [WD_W-1:0]  r_wd;
    logic             r_is_mem;
    logic             r_is_store;
    logic [CNT_W-1:0] r_instret;

    state_t           w_next_state;
    logic             w_req_acc_next;
    logic [WD_W-1:0]  w_wd_next;
    logic             w_imem_valid;
    logic             w_dmem_valid;
    logic             w_ir_we;
    logic             w_retire;

    // Next-state, handshake tracking, watchdog and strobe decode
    always_comb begin
        w_next_state   = r_state;
        w_req_acc_next = r_req_acc;
        w_wd_next      = r_wd;
        w_imem_valid   = 1'b0;
        w_dmem_valid   = 1'b0;
        w_ir_we        = 1'b0;
        w_retire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state   = S_FETCH;
                w_req_acc_next = 1'b0;
                w_wd_next      = '0;
            end
            S_FETCH: begin
                w_imem_valid = !r_req_acc;
                // A response only counts once the request was accepted on an earlier edge.
                if (r_req_acc && bus.imem_rsp_valid) begin
                    w_ir_we        = 1'b1;
                    w_next_state   = S_DECODE;
                    w_req_acc_next = 1'b0;
                    w_wd_next      = '0;
                end else begin
                    if (w_imem_valid && bus.imem_req_ready) begin
                        w_req_acc_next = 1'b1;
                    end else begin
                        w_req_acc_next = r_req_acc;
                    end
                    if (TIMEOUT == 0) begin
                        w_wd_next = r_wd;
                    end else if (r_wd == WD_LAST) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_wd_next = r_wd + WD_W'(1);
                    end
                end
            end
            S_DECODE: begin
                if (bus.dec_is_ebreak) begin
                    w_next_state = S_HALT;
                    w_retire     = 1'b1;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_is_mem) begin
                    w_next_state   = S_MEM;
                    w_req_acc_next = 1'b0;
                    w_wd_next      = '0;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                w_dmem_valid = !r_req_acc;
                if (r_req_acc && bus.dmem_rsp_valid) begin
                    w_next_state   = S_WB;
                    w_req_acc_next = 1'b0;
                    w_wd_next      = '0;
                end else begin
                    if (w_dmem_valid && bus.dmem_req_ready) begin
                        w_req_acc_next = 1'b1;
                    end else begin
                        w_req_acc_next = r_req_acc;
                    end
                    if (TIMEOUT == 0) begin
                        w_wd_next = r_wd;
                    end else if (r_wd == WD_LAST) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_wd_next = r_wd + WD_W'(1);
                    end
                end
            end
            S_WB: begin
                w_retire       = 1'b1;
                w_next_state   = S_FETCH;
                w_req_acc_next = 1'b0;
                w_wd_next      = '0;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            S_ERR: begin
                w_next_state = S_ERR;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, handshake, watchdog and retire-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req_acc  <= 1'b0;
            r_wd       <= '0;
            r_is_mem   <= 1'b0;
            r_is_store <= 1'b0;
            r_instret  <= '0;
        end else begin
            r_state   <= w_next_state;
            r_req_acc <= w_req_acc_next;
            r_wd      <= w_wd_next;
            // Decode flags are only trusted in DECODE; load+store together behaves as a store.
            if (r_state == S_DECODE) begin
                r_is_mem   <= bus.dec_is_load | bus.dec_is_store;
                r_is_store <= bus.dec_is_store;
            end else begin
                r_is_mem   <= r_is_mem;
                r_is_store <= r_is_store;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end else begin
                r_instret <= r_instret;
            end
        end
    end

    assign bus.imem_req_valid = w_imem_valid;
    assign bus.dmem_req_valid = w_dmem_valid;
    assign bus.dmem_req_wen   = w_dmem_valid & r_is_store;
    assign bus.ir_we          = w_ir_we;
    assign bus.rf_we          = (r_state == S_WB) & ~r_is_store;
    assign bus.pc_we          = (r_state == S_WB);
    assign bus.halt           = (r_state == S_HALT);
    assign bus.mem_timeout    = (r_state == S_ERR);
    assign bus.state          = r_state;
    assign bus.instret        = r_instret;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl (TIMEOUT=8, CNT_W=4): ALU/load/store
// sequencing, ebreak halt, watchdog expiry, reset mid-MEM and counter wrap.
module tb_core_seq_ctrl;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    core_seq_ctrl_if #(.CNT_W(4)) bus ();

    core_seq_ctrl #(.TIMEOUT(8), .CNT_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.dec_is_load    = 1'b0;
        bus.dec_is_store   = 1'b0;
        bus.dec_is_ebreak  = 1'b0;
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
    endtask

    // Leaves the DUT in IDLE with rst released; the next edge enters FETCH.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // From FETCH: accept on the first edge, respond on the next -> DECODE.
    task automatic fetch_to_decode();
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_rsp_valid = 1'b1;
        tick();
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic alu_one();
        fetch_to_decode();
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.state !== 3'd0) begin $display("FAIL reset_state got=%0d exp=0", bus.state); errors++; end
        checks++; if ({bus.imem_req_valid, bus.dmem_req_valid, bus.dmem_req_wen, bus.ir_we, bus.rf_we, bus.pc_we, bus.halt, bus.mem_timeout} !== 8'h00) begin
            $display("FAIL reset_outputs got=%b exp=00000000", {bus.imem_req_valid, bus.dmem_req_valid, bus.dmem_req_wen, bus.ir_we, bus.rf_we, bus.pc_we, bus.halt, bus.mem_timeout}); errors++; end
        checks++; if (bus.instret !== 4'd0) begin $display("FAIL reset_instret got=%0d exp=0", bus.instret); errors++; end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        do_reset();
        checks++; if (bus.state !== 3'd0) begin $display("FAIL alu_idle got=%0d exp=0", bus.state); errors++; end
        bus.imem_req_ready = 1'b1;
        tick();
        checks++; if (bus.state !== 3'd1 || bus.imem_req_valid !== 1'b1) begin $display("FAIL alu_fetch state=%0d valid=%b exp=1/1", bus.state, bus.imem_req_valid); errors++; end
        tick();
        checks++; if (bus.state !== 3'd1 || bus.imem_req_valid !== 1'b0) begin $display("FAIL alu_accepted state=%0d valid=%b exp=1/0", bus.state, bus.imem_req_valid); errors++; end
        bus.imem_rsp_valid = 1'b1;
        #1;
        checks++; if (bus.ir_we !== 1'b1) begin $display("FAIL alu_ir_we got=%b exp=1", bus.ir_we); errors++; end
        tick();
        bus.imem_rsp_valid = 1'b0;
        checks++; if (bus.state !== 3'd2 || bus.ir_we !== 1'b0) begin $display("FAIL alu_decode state=%0d ir_we=%b exp=2/0", bus.state, bus.ir_we); errors++; end
        tick();
        checks++; if (bus.state !== 3'd3) begin $display("FAIL alu_exec got=%0d exp=3", bus.state); errors++; end
        tick();
        checks++; if (bus.state !== 3'd5 || {bus.pc_we, bus.rf_we} !== 2'b11 || bus.instret !== 4'd0) begin
            $display("FAIL alu_wb state=%0d pc_rf=%b instret=%0d exp=5/11/0", bus.state, {bus.pc_we, bus.rf_we}, bus.instret); errors++; end
        tick();
        checks++; if (bus.state !== 3'd1 || bus.instret !== 4'd1 || bus.pc_we !== 1'b0) begin
            $display("FAIL alu_retire state=%0d instret=%0d pc_we=%b exp=1/1/0", bus.state, bus.instret, bus.pc_we); errors++; end
    endtask

    // Enters from FETCH. is_store=1 drives load and store both high.
    task automatic test_mem(input logic is_store, input logic [3:0] exp_instret);
        logic bad;
        fetch_to_decode();
        bus.dec_is_load  = 1'b1;
        bus.dec_is_store = is_store;
        tick();
        checks++; if (bus.state !== 3'd3) begin $display("FAIL mem_exec got=%0d exp=3", bus.state); errors++; end
        tick();
        clear_inputs();
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.state !== 3'd4 || bus.dmem_req_valid !== 1'b1 || bus.dmem_req_wen !== is_store) bad = 1'b1;
            tick();
        end
        checks++; if (bad !== 1'b0) begin $display("FAIL mem_req_hold store=%b state=%0d valid=%b wen=%b", is_store, bus.state, bus.dmem_req_valid, bus.dmem_req_wen); errors++; end
        bus.dmem_req_ready = 1'b1;
        tick();
        bus.dmem_req_ready = 1'b0;
        checks++; if (bus.state !== 3'd4 || bus.dmem_req_valid !== 1'b0) begin $display("FAIL mem_accepted state=%0d valid=%b exp=4/0", bus.state, bus.dmem_req_valid); errors++; end
        bus.dmem_rsp_valid = 1'b1;
        tick();
        bus.dmem_rsp_valid = 1'b0;
        checks++; if (bus.state !== 3'd5 || bus.rf_we !== ~is_store || bus.pc_we !== 1'b1) begin
            $display("FAIL mem_wb store=%b state=%0d rf_we=%b pc_we=%b", is_store, bus.state, bus.rf_we, bus.pc_we); errors++; end
        tick();
        checks++; if (bus.state !== 3'd1 || bus.instret !== exp_instret) begin $display("FAIL mem_retire state=%0d instret=%0d exp=1/%0d", bus.state, bus.instret, exp_instret); errors++; end
    endtask

    task automatic test_halt();
        logic bad;
        do_reset();
        tick();
        alu_one();
        fetch_to_decode();
        bus.dec_is_ebreak = 1'b1;
        bus.dec_is_load   = 1'b1;
        tick();
        clear_inputs();
        checks++; if (bus.state !== 3'd6 || bus.halt !== 1'b1 || bus.instret !== 4'd2 || {bus.pc_we, bus.rf_we} !== 2'b00) begin
            $display("FAIL halt_entry state=%0d halt=%b instret=%0d pc_rf=%b exp=6/1/2/00", bus.state, bus.halt, bus.instret, {bus.pc_we, bus.rf_we}); errors++; end
        bus.imem_req_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.imem_req_valid !== 1'b0 || bus.state !== 3'd6 || bus.halt !== 1'b1 || bus.instret !== 4'd2) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin $display("FAIL halt_sticky state=%0d imem_valid=%b instret=%0d", bus.state, bus.imem_req_valid, bus.instret); errors++; end
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        for (int i = 0; i < 17; i++) alu_one();
        checks++; if (bus.instret !== 4'd1 || bus.state !== 3'd1) begin $display("FAIL wrap instret=%0d state=%0d exp=1/1", bus.instret, bus.state); errors++; end
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        bus.imem_req_ready = 1'b1;
        repeat (7) tick();
        checks++; if (bus.state !== 3'd1) begin $display("FAIL timeout_early got=%0d exp=1", bus.state); errors++; end
        tick();
        checks++; if (bus.state !== 3'd7 || bus.mem_timeout !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
            $display("FAIL timeout_err state=%0d mem_timeout=%b valid=%b exp=7/1/0", bus.state, bus.mem_timeout, bus.imem_req_valid); errors++; end
        bus.imem_rsp_valid = 1'b1;
        #1;
        checks++; if (bus.ir_we !== 1'b0) begin $display("FAIL timeout_ir_we got=%b exp=0", bus.ir_we); errors++; end
        tick();
        checks++; if (bus.state !== 3'd7) begin $display("FAIL timeout_sticky got=%0d exp=7", bus.state); errors++; end
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.state !== 3'd0 || bus.mem_timeout !== 1'b0 || bus.halt !== 1'b0) begin
            $display("FAIL timeout_rst state=%0d mem_timeout=%b halt=%b exp=0/0/0", bus.state, bus.mem_timeout, bus.halt); errors++; end
    endtask

    task automatic test_rsp_at_limit();
        do_reset();
        tick();
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        #1;
        checks++; if (bus.ir_we !== 1'b0) begin $display("FAIL early_rsp_ir_we got=%b exp=0", bus.ir_we); errors++; end
        tick();
        bus.imem_rsp_valid = 1'b0;
        checks++; if (bus.state !== 3'd1 || bus.imem_req_valid !== 1'b0) begin $display("FAIL early_rsp_ignored state=%0d valid=%b exp=1/0", bus.state, bus.imem_req_valid); errors++; end
        repeat (6) tick();
        bus.imem_rsp_valid = 1'b1;
        #1;
        checks++; if (bus.state !== 3'd1 || bus.ir_we !== 1'b1) begin $display("FAIL limit_rsp state=%0d ir_we=%b exp=1/1", bus.state, bus.ir_we); errors++; end
        tick();
        bus.imem_rsp_valid = 1'b0;
        checks++; if (bus.state !== 3'd2) begin $display("FAIL limit_rsp_wins got=%0d exp=2", bus.state); errors++; end
    endtask

    task automatic test_rst_mid_mem();
        do_reset();
        tick();
        fetch_to_decode();
        bus.dec_is_load = 1'b1;
        tick();
        tick();
        clear_inputs();
        bus.dmem_req_ready = 1'b1;
        tick();
        bus.dmem_req_ready = 1'b0;
        checks++; if (bus.state !== 3'd4 || bus.dmem_req_valid !== 1'b0) begin $display("FAIL rstmem_accepted state=%0d valid=%b exp=4/0", bus.state, bus.dmem_req_valid); errors++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.state !== 3'd0 || bus.dmem_req_valid !== 1'b0) begin $display("FAIL rstmem_idle state=%0d valid=%b exp=0/0", bus.state, bus.dmem_req_valid); errors++; end
        bus.dmem_rsp_valid = 1'b1;
        tick();
        bus.dmem_rsp_valid = 1'b0;
        checks++; if (bus.state !== 3'd1 || bus.imem_req_valid !== 1'b1 || bus.dmem_req_valid !== 1'b0 || bus.rf_we !== 1'b0) begin
            $display("FAIL rstmem_late_rsp state=%0d imem=%b dmem=%b rf_we=%b exp=1/1/0/0", bus.state, bus.imem_req_valid, bus.dmem_req_valid, bus.rf_we); errors++; end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_alu();
        test_mem(1'b0, 4'd2);
        test_mem(1'b1, 4'd3);
        test_halt();
        test_wrap();
        test_timeout();
        test_rsp_at_limit();
        test_rst_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
